// File: rtl/obstacle_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_scheduler_if
//  Description : Bundle of frame-timing, slot-status and launch signals that
//                connect a game controller (master) to obstacle_scheduler
//                (slave).
//                  i_ani_stb  frame strobe, one clock per frame
//                  i_animate  game running; low freezes scheduling
//                  i_clear    synchronous restart to the grace period
//                  i_busy     per-slot occupied flag
//                  o_launch   one-hot single-cycle launch pulse
//                  o_rnd      random value latched with each launch
//                  o_grace    high while in the grace period
//                  o_gap      current gap countdown, saturated at 255
//  Revision    : 1.0  initial release
// ============================================================================
interface obstacle_scheduler_if #(
    parameter int NSLOT = 4
);
    logic             i_ani_stb;
    logic             i_animate;
    logic             i_clear;
    logic [NSLOT-1:0] i_busy;
    logic [NSLOT-1:0] o_launch;
    logic [3:0]       o_rnd;
    logic             o_grace;
    logic [7:0]       o_gap;

    modport master (
        output i_ani_stb, i_animate, i_clear, i_busy,
        input  o_launch, o_rnd, o_grace, o_gap
    );

    modport slave (
        input  i_ani_stb, i_animate, i_clear, i_busy,
        output o_launch, o_rnd, o_grace, o_gap
    );
endinterface
`default_nettype wire

// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : obstacle_scheduler
//  Description : Decides when and into which slot the next obstacle is
//                launched. After reset or clear a grace period of
//                GRACE_FRAMES frames runs, then the block alternates between
//                counting down a randomised gap (MIN_GAP + 0..30 frames) and
//                picking the next free slot round-robin.
//  Ports       : i_clk    base clock, rising edge
//                i_rst_n  asynchronous active-low reset
//                bus      obstacle_scheduler_if.slave (strobe, animate,
//                         clear, busy in; launch, rnd, grace, gap out)
//  Revision    : 1.0  initial release
// ============================================================================
module obstacle_scheduler #(
    parameter int          NSLOT        = 4,
    parameter int          MIN_GAP      = 60,
    parameter int          GRACE_FRAMES = 120,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst_n,
    obstacle_scheduler_if.slave  bus
);

    localparam int          PW          = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam logic [15:0] C_LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        GRACE = 2'd0,
        WAIT  = 2'd1,
        PICK  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [15:0]      grace_cnt_q, grace_cnt_d;
    logic [8:0]       gap_cnt_q,   gap_cnt_d;
    logic [PW-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [15:0]      lfsr_q,      lfsr_d;
    logic [NSLOT-1:0] launch_q,    launch_d;
    logic [3:0]       rnd_q,       rnd_d;
    logic             grace_q,     grace_d;
    logic [7:0]       gap_q,       gap_d;

    logic             w_tick;
    logic             w_found;
    logic [PW-1:0]    w_sel;
    logic [PW-1:0]    w_idx;
    logic [8:0]       w_gap_first;
    logic [8:0]       w_gap_next;

    assign w_tick      = bus.i_ani_stb & bus.i_animate;
    // Gap reloads: low nibble of the LFSR after grace, next nibble after a
    // launch, so the launch value on o_rnd and the following gap differ.
    assign w_gap_first = 9'(MIN_GAP) + {4'b0000, lfsr_q[3:0], 1'b0};
    assign w_gap_next  = 9'(MIN_GAP) + {4'b0000, lfsr_q[7:4], 1'b0};

    // First free slot starting at rr_ptr and wrapping modulo NSLOT.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NSLOT; i++) begin
            w_idx = PW'((int'(rr_ptr_q) + i) % NSLOT);
            if (!w_found && !bus.i_busy[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        // Galois LFSR, free-running regardless of animate or clear
        lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ C_LFSR_MASK) : (lfsr_q >> 1);
        state_d     = state_q;
        grace_cnt_d = grace_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        launch_d    = '0;
        rnd_d       = rnd_q;

        if (bus.i_clear) begin
            state_d     = GRACE;
            grace_cnt_d = 16'(GRACE_FRAMES);
            gap_cnt_d   = 9'd0;
        end else begin
            case (state_q)
                GRACE: begin
                    if (w_tick) begin
                        grace_cnt_d = grace_cnt_q - 16'd1;
                        if (grace_cnt_q <= 16'd1) begin
                            state_d   = WAIT;
                            gap_cnt_d = w_gap_first;
                        end
                    end
                end
                WAIT: begin
                    // Expiry is checked every cycle, not only on ticks
                    if (gap_cnt_q == 9'd0) begin
                        state_d = PICK;
                    end else if (w_tick) begin
                        gap_cnt_d = gap_cnt_q - 9'd1;
                    end
                end
                PICK: begin
                    // No free slot or paused: stay here and retry next cycle
                    if (bus.i_animate && w_found) begin
                        launch_d  = NSLOT'(1) << w_sel;
                        rnd_d     = lfsr_q[3:0];
                        rr_ptr_d  = (w_sel == PW'(NSLOT - 1)) ? '0 : w_sel + PW'(1);
                        gap_cnt_d = w_gap_next;
                        state_d   = WAIT;
                    end
                end
                default: begin
                    state_d = GRACE;
                end
            endcase
        end

        grace_d = (state_d == GRACE);
        gap_d   = (gap_cnt_d > 9'd255) ? 8'hFF : gap_cnt_d[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= GRACE;
            grace_cnt_q <= 16'(GRACE_FRAMES);
            gap_cnt_q   <= 9'd0;
            rr_ptr_q    <= '0;
            lfsr_q      <= SEED;
            launch_q    <= '0;
            rnd_q       <= 4'd0;
            grace_q     <= 1'b1;
            gap_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            grace_cnt_q <= grace_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            lfsr_q      <= lfsr_d;
            launch_q    <= launch_d;
            rnd_q       <= rnd_d;
            grace_q     <= grace_d;
            gap_q       <= gap_d;
        end
    end

    assign bus.o_launch = launch_q;
    assign bus.o_rnd    = rnd_q;
    assign bus.o_grace  = grace_q;
    assign bus.o_gap    = gap_q;

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obstacle_scheduler
//  Description : Self-checking bench for obstacle_scheduler with a frame-level
//                reference model, directed scenarios and a randomised run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_obstacle_scheduler;

    localparam int          NSLOT        = 4;
    localparam int          MIN_GAP      = 8;
    localparam int          GRACE_FRAMES = 4;
    localparam logic [15:0] SEED         = 16'hACE1;

    localparam int PH_GRACE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_PICK  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    obstacle_scheduler_if #(.NSLOT(NSLOT)) bus ();

    obstacle_scheduler #(
        .NSLOT        (NSLOT),
        .MIN_GAP      (MIN_GAP),
        .GRACE_FRAMES (GRACE_FRAMES),
        .SEED         (SEED)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Frame strobe: period N gives one strobe every N clocks, 0 gives random.
    int stb_period = 4;
    int stb_cnt    = 0;
    always @(negedge clk) begin
        if (stb_period <= 0) begin
            bus.i_ani_stb = 1'($urandom_range(0, 1));
        end else begin
            bus.i_ani_stb = (stb_cnt == 0);
            stb_cnt       = (stb_cnt + 1) % stb_period;
        end
    end

    // ------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------
    logic [15:0] m_lfsr, m_l;
    int          m_phase, m_grace, m_gap, m_rr, m_k;
    bit          m_tick, m_found;
    logic [3:0]  exp_launch, exp_rnd, busy_at_edge;
    logic        exp_grace;
    int          exp_gap;
    int          tick_count;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr       = SEED;
            m_phase      = PH_GRACE;
            m_grace      = GRACE_FRAMES;
            m_gap        = 0;
            m_rr         = 0;
            exp_launch   = '0;
            exp_rnd      = '0;
            busy_at_edge = '0;
            tick_count   = 0;
        end else begin
            m_l          = m_lfsr;
            m_tick       = (bus.i_ani_stb === 1'b1) && (bus.i_animate === 1'b1);
            busy_at_edge = bus.i_busy;
            exp_launch   = '0;
            if (m_tick) tick_count++;
            m_lfsr = {1'b0, m_l[15:1]} ^ (m_l[0] ? 16'hB400 : 16'h0000);
            if (bus.i_clear === 1'b1) begin
                m_phase = PH_GRACE;
                m_grace = GRACE_FRAMES;
                m_gap   = 0;
            end else if (m_phase == PH_GRACE) begin
                if (m_tick) begin
                    if (m_grace == 1) begin
                        m_phase = PH_WAIT;
                        m_gap   = MIN_GAP + 2 * int'(m_l[3:0]);
                    end
                    m_grace--;
                end
            end else if (m_phase == PH_WAIT) begin
                if (m_gap == 0)  m_phase = PH_PICK;
                else if (m_tick) m_gap--;
            end else if (bus.i_animate === 1'b1) begin
                m_found = 1'b0;
                for (int i = 0; i < NSLOT; i++) begin
                    m_k = (m_rr + i) % NSLOT;
                    if (!m_found && bus.i_busy[m_k] == 1'b0) begin
                        m_found    = 1'b1;
                        exp_launch = 4'(1 << m_k);
                        exp_rnd    = m_l[3:0];
                        m_rr       = (m_k + 1) % NSLOT;
                        m_gap      = MIN_GAP + 2 * int'(m_l[7:4]);
                        m_phase    = PH_WAIT;
                    end
                end
            end
        end
        exp_grace = (m_phase == PH_GRACE);
        exp_gap   = (m_gap > 255) ? 255 : m_gap;
    end

    // ------------------------------------------------------------------
    // Per-cycle monitor (forked from the main initial block)
    // ------------------------------------------------------------------
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                checks += 6;
                if (bus.o_launch !== exp_launch) begin
                    errors++;
                    $display("FAIL mon_launch t=%0t: got %b want %b", $time, bus.o_launch, exp_launch);
                end
                if (bus.o_rnd !== exp_rnd) begin
                    errors++;
                    $display("FAIL mon_rnd t=%0t: got %0d want %0d", $time, bus.o_rnd, exp_rnd);
                end
                if (bus.o_grace !== exp_grace) begin
                    errors++;
                    $display("FAIL mon_grace t=%0t: got %b want %b", $time, bus.o_grace, exp_grace);
                end
                if (bus.o_gap !== 8'(exp_gap)) begin
                    errors++;
                    $display("FAIL mon_gap t=%0t: got %0d want %0d", $time, bus.o_gap, exp_gap);
                end
                if ((bus.o_launch & (bus.o_launch - 4'd1)) !== 4'd0) begin
                    errors++;
                    $display("FAIL mon_onehot t=%0t: got %b want at most one bit", $time, bus.o_launch);
                end
                if ((bus.o_launch & busy_at_edge) !== 4'd0) begin
                    errors++;
                    $display("FAIL mon_busy t=%0t: launch %b busy %b want no overlap", $time, bus.o_launch, busy_at_edge);
                end
            end
        end
    endtask

    task automatic wait_launch(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (bus.o_launch != '0) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int slot_of(input logic [3:0] v);
        for (int i = 0; i < NSLOT; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.i_animate = 1'b0;
        bus.i_clear   = 1'b0;
        bus.i_busy    = '0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.o_launch !== 4'd0) begin errors++; $display("FAIL reset_launch: got %b want 0000", bus.o_launch); end
        if (bus.o_rnd !== 4'd0)    begin errors++; $display("FAIL reset_rnd: got %0d want 0", bus.o_rnd); end
        if (bus.o_grace !== 1'b1)  begin errors++; $display("FAIL reset_grace: got %b want 1", bus.o_grace); end
        if (bus.o_gap !== 8'd0)    begin errors++; $display("FAIL reset_gap: got %0d want 0", bus.o_gap); end
    endtask

    task automatic test_grace();
        bit seen = 1'b0;
        bus.i_animate = 1'b1;
        stb_period    = 4;
        mon_en        = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_grace === 1'b0) seen = 1'b1;
        end
        checks += 3;
        if (!seen) begin errors++; $display("FAIL grace_end: o_grace still %b want 0 within 100 cycles", bus.o_grace); end
        if (tick_count != GRACE_FRAMES) begin errors++; $display("FAIL grace_ticks: got %0d want %0d", tick_count, GRACE_FRAMES); end
        if (bus.o_gap < 8'd8 || bus.o_gap > 8'd38) begin errors++; $display("FAIL grace_gap: got %0d want 8..38", bus.o_gap); end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int last_tick = 0;
        bit prev_nz = 1'b0;
        bus.i_busy = '0;
        stb_period = 1;
        for (int c = 0; c < 2000 && n < 5; c++) begin
            @(negedge clk);
            if (bus.o_launch != '0) begin
                checks++;
                if (bus.o_launch !== 4'(1 << (n % NSLOT))) begin
                    errors++;
                    $display("FAIL rr_slot%0d: got %b want %b", n, bus.o_launch, 4'(1 << (n % NSLOT)));
                end
                if (n > 0) begin
                    checks++;
                    if (tick_count - last_tick < MIN_GAP) begin
                        errors++;
                        $display("FAIL rr_spacing%0d: got %0d frames want >= %0d", n, tick_count - last_tick, MIN_GAP);
                    end
                end
                checks++;
                if (prev_nz) begin errors++; $display("FAIL rr_width%0d: got 2+ cycle pulse want 1", n); end
                last_tick = tick_count;
                n++;
            end
            prev_nz = (bus.o_launch != '0);
        end
        checks++;
        if (n < 5) begin errors++; $display("FAIL rr_count: got %0d launches want 5", n); end
    endtask

    task automatic test_busy_skip();
        bit ok;
        do_reset();
        bus.i_busy = 4'b1011;
        stb_period = 1;
        wait_launch(300, ok);
        checks++;
        if (!ok || bus.o_launch !== 4'b0100) begin errors++; $display("FAIL skip_slot2: got %b want 0100", bus.o_launch); end
        bus.i_busy = 4'b1111;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_launch !== 4'd0) begin errors++; $display("FAIL stall_nopulse: got %b want 0000", bus.o_launch); end
        end
        checks += 2;
        if (bus.o_gap !== 8'd0)   begin errors++; $display("FAIL stall_gap: got %0d want 0", bus.o_gap); end
        if (bus.o_grace !== 1'b0) begin errors++; $display("FAIL stall_grace: got %b want 0", bus.o_grace); end
        bus.i_busy = 4'b1101;
        @(negedge clk);
        checks++;
        if (bus.o_launch !== 4'b0010) begin errors++; $display("FAIL unstall_slot1: got %b want 0010", bus.o_launch); end
        bus.i_busy = '0;
    endtask

    task automatic test_pause();
        bit seen = 1'b0;
        int tc;
        bus.i_busy = '0;
        stb_period = 1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_gap === 8'd5 && bus.o_grace === 1'b0) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL pause_reach5: got gap %0d want 5", bus.o_gap); end
        bus.i_animate = 1'b0;
        stb_period    = 2;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks += 2;
            if (bus.o_gap !== 8'd5)    begin errors++; $display("FAIL pause_hold: got %0d want 5", bus.o_gap); end
            if (bus.o_launch !== 4'd0) begin errors++; $display("FAIL pause_nolaunch: got %b want 0000", bus.o_launch); end
        end
        bus.i_animate = 1'b1;
        tc   = tick_count;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (tick_count != tc) seen = 1'b1;
        end
        checks++;
        if (!seen || bus.o_gap !== 8'd4) begin errors++; $display("FAIL pause_resume: got %0d want 4", bus.o_gap); end
    endtask

    task automatic test_clear();
        bit ok;
        int k;
        bus.i_busy = '0;
        stb_period = 1;
        wait_launch(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clear_prelaunch: got none want a launch"); end
        k = slot_of(bus.o_launch);
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        checks += 3;
        if (bus.o_launch !== 4'd0) begin errors++; $display("FAIL clear_launch: got %b want 0000", bus.o_launch); end
        if (bus.o_grace !== 1'b1)  begin errors++; $display("FAIL clear_grace: got %b want 1", bus.o_grace); end
        if (bus.o_gap !== 8'd0)    begin errors++; $display("FAIL clear_gap: got %0d want 0", bus.o_gap); end
        wait_launch(300, ok);
        checks++;
        if (!ok || bus.o_launch !== 4'(1 << ((k + 1) % NSLOT))) begin
            errors++;
            $display("FAIL clear_rr_kept: got %b want %b", bus.o_launch, 4'(1 << ((k + 1) % NSLOT)));
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit ok;
        wait_launch(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rstpulse_prelaunch: got none want a launch"); end
        #1 rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.o_launch !== 4'd0) begin errors++; $display("FAIL rstpulse_launch: got %b want 0000", bus.o_launch); end
        if (bus.o_grace !== 1'b1)  begin errors++; $display("FAIL rstpulse_grace: got %b want 1", bus.o_grace); end
        if (bus.o_rnd !== 4'd0)    begin errors++; $display("FAIL rstpulse_rnd: got %0d want 0", bus.o_rnd); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int launches = 0;
        stb_period = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (bus.o_launch != '0) launches++;
            bus.i_animate = ($urandom_range(0, 7) != 0);
            bus.i_busy    = 4'($urandom);
            bus.i_clear   = ($urandom_range(0, 299) == 0);
        end
        bus.i_clear = 1'b0;
        checks++;
        if (launches < 10) begin errors++; $display("FAIL random_activity: got %0d launches want >= 10", launches); end
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        test_reset();
        test_grace();
        test_round_robin();
        test_busy_skip();
        test_pause();
        test_clear();
        test_reset_mid_pulse();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
